// File: rtl/operand_fetch_stage_pkg.sv
// Shared definitions for the operand fetch stage: instruction field
// positions, the format-2 opcode, FSM state encoding and small helpers.
package operand_fetch_stage_pkg;

  // SPARC instruction field positions
  localparam int OP_HI    = 31;
  localparam int OP_LO    = 30;
  localparam int RS1_HI   = 18;
  localparam int RS1_LO   = 14;
  localparam int RS2_HI   = 4;
  localparam int RS2_LO   = 0;
  localparam int IMM22_HI = 21;

  // op field value of format-2 instructions (sethi / branches)
  localparam logic [1:0] FMT2 = 2'b00;

  // FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RD   = 2'd1;
  localparam state_t ST_HOLD = 2'd2;

  // Format-2 instructions carry no register sources
  function automatic logic is_fmt2(input logic [31:0] instr);
    return (instr[OP_HI:OP_LO] == FMT2);
  endfunction

  // %g0 always reads as zero, whatever the register file returns
  function automatic logic [31:0] g0_mask(input logic [4:0] addr,
                                          input logic [31:0] data);
    return (addr == 5'd0) ? 32'h0000_0000 : data;
  endfunction

endpackage

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: accepts an instruction, reads rs1/rs2 from a
// register file with RD_LAT cycles of latency and presents the operand
// bundle (IS, R, Imm, rs1 value) to the execute-side operand path.
module operand_fetch_stage
  import operand_fetch_stage_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic [4:0]  rf_rs1_addr,
  output logic [4:0]  rf_rs2_addr,
  input  logic [31:0] rf_rs1_data,
  input  logic [31:0] rf_rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_is,
  output logic [31:0] out_r,
  output logic [21:0] out_imm,
  output logic [31:0] out_rs1
);

  localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

  state_t      state_q,    state_d;
  logic [31:0] instr_q,    instr_d;
  logic [4:0]  rs1_addr_q, rs1_addr_d;
  logic [4:0]  rs2_addr_q, rs2_addr_d;
  logic [31:0] r_q,        r_d;
  logic [31:0] rs1_q,      rs1_d;
  logic [1:0]  lat_cnt_q,  lat_cnt_d;
  logic        valid_q,    valid_d;
  logic        in_ready_s;
  logic        accept_s;

  // Upstream ready: open in IDLE, pass-through of out_ready in HOLD, closed on flush
  always_comb begin
    in_ready_s = 1'b0;
    case (state_q)
      ST_IDLE: in_ready_s = 1'b1;
      ST_RD:   in_ready_s = 1'b0;
      ST_HOLD: in_ready_s = out_ready;
      default: in_ready_s = 1'b0;
    endcase
    if (flush) begin
      in_ready_s = 1'b0;
    end else begin
      in_ready_s = in_ready_s;
    end
  end

  assign accept_s = in_valid & in_ready_s;

  // Next-state logic: instruction load, RF latency count, capture and hand-off
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    rs1_addr_d = rs1_addr_q;
    rs2_addr_d = rs2_addr_q;
    r_d        = r_q;
    rs1_d      = rs1_q;
    lat_cnt_d  = lat_cnt_q;

    if (flush) begin
      // Flush beats everything; any RF data still in flight is dropped
      state_d   = ST_IDLE;
      lat_cnt_d = 2'd0;
    end else if (accept_s) begin
      // Same load path from IDLE and from HOLD (back-to-back accept)
      instr_d = in_instr;
      if (is_fmt2(in_instr)) begin
        r_d     = 32'h0000_0000;
        rs1_d   = 32'h0000_0000;
        state_d = ST_HOLD;
      end else begin
        rs1_addr_d = in_instr[RS1_HI:RS1_LO];
        rs2_addr_d = in_instr[RS2_HI:RS2_LO];
        lat_cnt_d  = LAT_INIT;
        state_d    = ST_RD;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_RD: begin
          if (lat_cnt_q != 2'd0) begin
            lat_cnt_d = lat_cnt_q - 2'd1;
          end else begin
            rs1_d   = g0_mask(rs1_addr_q, rf_rs1_data);
            r_d     = g0_mask(rs2_addr_q, rf_rs2_data);
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HOLD;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    valid_d = (state_d == ST_HOLD);
  end

  // State and bundle registers, cleared asynchronously on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      instr_q    <= 32'h0000_0000;
      rs1_addr_q <= 5'd0;
      rs2_addr_q <= 5'd0;
      r_q        <= 32'h0000_0000;
      rs1_q      <= 32'h0000_0000;
      lat_cnt_q  <= 2'd0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      rs1_addr_q <= rs1_addr_d;
      rs2_addr_q <= rs2_addr_d;
      r_q        <= r_d;
      rs1_q      <= rs1_d;
      lat_cnt_q  <= lat_cnt_d;
      valid_q    <= valid_d;
    end
  end

  assign in_ready    = in_ready_s;
  assign rf_rs1_addr = rs1_addr_q;
  assign rf_rs2_addr = rs2_addr_q;
  assign out_valid   = valid_q;
  assign out_is      = instr_q;
  assign out_r       = r_q;
  assign out_imm     = instr_q[IMM22_HI:0];
  assign out_rs1     = rs1_q;

endmodule
